// File: rtl/rrb_request_agent.sv
// Requester agent for the weighted round-robin arbiter: per-channel job counters drive request, grants consume jobs, grant protocol is policed.
// Latency: push -> request one cycle; grant -> served/request/err_* one cycle; job_ready and pending_count are combinational from the counters.
// Backpressure: job_ready drops when a counter is full; a push while full is dropped unless the same channel consumes that cycle.
module rrb_request_agent #(
    parameter int channels  = 8,
    parameter int width     = 32,
    parameter int cnt_width = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [channels-1:0]           job_push,
    output logic [channels-1:0]           job_ready,
    input  logic [channels-1:0]           grant,
    input  logic [channels*width-1:0]     weight,
    output logic [channels-1:0]           request,
    output logic [channels-1:0]           served,
    output logic [channels*cnt_width-1:0] pending_count,
    output logic                          err_multi,
    output logic                          err_spurious,
    output logic                          err_overrun
);

    localparam logic [cnt_width-1:0] cnt_max = '1;
    localparam logic [cnt_width-1:0] cnt_one = cnt_width'(1);
    localparam logic [width-1:0]     ten_max = '1;
    localparam logic [width-1:0]     ten_one = width'(1);

    logic [cnt_width-1:0] count     [channels];
    logic [cnt_width-1:0] count_nxt [channels];
    logic [channels-1:0]  consume;
    logic [channels-1:0]  req_prev;
    logic [channels-1:0]  prev_grant;
    logic [width-1:0]     tenure;
    logic [width-1:0]     tenure_nxt;
    logic [width-1:0]     grant_weight;
    logic [width-1:0]     eff_weight;
    logic                 grant_onehot;
    logic                 grant_multi;

    assign grant_onehot = $onehot(grant);
    assign grant_multi  = $countones(grant) > 1;

    // A multi-bit grant is treated as invalid: nobody consumes that cycle.
    always_comb begin
        for (int i = 0; i < channels; i++) begin
            job_ready[i] = (count[i] != cnt_max);
            pending_count[i*cnt_width +: cnt_width] = count[i];
            consume[i]   = grant[i] && (count[i] != '0) && !grant_multi;
            count_nxt[i] = count[i];
            if (job_push[i] && !consume[i] && job_ready[i])
                count_nxt[i] = count[i] + cnt_one;
            else if (!job_push[i] && consume[i])
                count_nxt[i] = count[i] - cnt_one;
        end
    end

    always_comb begin
        grant_weight = '0;
        for (int i = 0; i < channels; i++) begin
            if (grant[i])
                grant_weight = weight[i*width +: width];
        end
        eff_weight = (grant_weight == '0) ? ten_one : grant_weight;
    end

    // Tenure restarts on any new one-hot grant and saturates rather than wrapping.
    always_comb begin
        tenure_nxt = '0;
        if (grant_onehot) begin
            if (grant == prev_grant)
                tenure_nxt = (tenure == ten_max) ? tenure : tenure + ten_one;
            else
                tenure_nxt = ten_one;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < channels; i++)
                count[i] <= '0;
            request      <= '0;
            served       <= '0;
            req_prev     <= '0;
            prev_grant   <= '0;
            tenure       <= '0;
            err_multi    <= 1'b0;
            err_spurious <= 1'b0;
            err_overrun  <= 1'b0;
        end else begin
            for (int i = 0; i < channels; i++) begin
                count[i]   <= count_nxt[i];
                request[i] <= (count_nxt[i] != '0);
            end
            served       <= consume;
            req_prev     <= request;
            prev_grant   <= grant;
            tenure       <= tenure_nxt;
            err_multi    <= err_multi | grant_multi;
            // Grant is legal while request is high or one cycle after it fell.
            err_spurious <= err_spurious | (|(grant & ~(request | req_prev)));
            err_overrun  <= err_overrun | (grant_onehot && (tenure_nxt > eff_weight));
        end
    end

endmodule
